// File: rtl/root_pkg.sv
// root_pkg -- shared definitions for the integer n-th root engine.
// Holds the FSM state encoding, datapath widths and the first bit index
// tried by the bit-by-bit root search.
package root_pkg;

    localparam int DATA_W    = 32;   // radicand / degree / result width
    localparam int ACC_W     = 64;   // power accumulator width
    localparam int START_BIT = 15;   // root of a 32-bit value fits in 16 bits

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETBIT,
        S_POWER,
        S_DECIDE,
        S_FIN
    } state_t;

endpackage

// File: rtl/root_pow_step.sv
// root_pow_step -- one combinational step of trial^n: acc * trial, clamped.
// Once the running power exceeds ix, the exact value no longer matters, so
// it is clamped to ix+1. That keeps acc <= 2^32+1 and the product < 2^49,
// so the 64-bit accumulator can never wrap.
// Ports:
//   i_acc   [ACC_W-1:0]  running power
//   i_trial [15:0]       trial root
//   i_ix    [DATA_W-1:0] radicand
//   o_acc   [ACC_W-1:0]  next running power (clamped to ix+1)
//   o_ovf                product exceeded ix (clamp applied)
module root_pow_step
    import root_pkg::*;
(
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [15:0]       i_trial,
    input  logic [DATA_W-1:0] i_ix,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_ovf
);

    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] w_ix_ext;

    assign w_ix_ext = ACC_W'(i_ix);
    assign w_prod   = i_acc * ACC_W'(i_trial);
    assign o_ovf    = (w_prod > w_ix_ext);
    assign o_acc    = o_ovf ? (w_ix_ext + ACC_W'(1)) : w_prod;

endmodule

// File: rtl/int_root.sv
// int_root -- sequential floor(ix^(1/n)) by bit-by-bit root search.
// For each bit 15..0, the engine forms trial = root | bit and raises it to
// the n-th power by repeated multiplication. It keeps the bit if
// trial^n <= ix. Trivial cases (n==0, ix==0, n==1, n>=32) finish straight
// from CHECK.
// Optional build macro ROOT_EARLY_EXIT_EN: POWER leaves as soon as the
// power exceeds ix. Further multiplies cannot change the decision, so only
// latency changes.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   start        request, sampled only in IDLE
//   ix [31:0]    radicand, captured on accepted start
//   in [31:0]    root degree n, captured on accepted start
//   busy         high from CHECK through FIN
//   done         one-cycle pulse in FIN, result/err valid
//   err          n == 0
//   result[31:0] root, held between operations
module int_root
    import root_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] ix,
    input  logic [DATA_W-1:0] in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_ix, r_n, r_result;
    logic [15:0]       r_root, r_trial;
    logic [3:0]        r_bit;
    logic [ACC_W-1:0]  r_acc;
    logic [5:0]        r_cnt;
    logic              r_err;

    logic [ACC_W-1:0]  w_acc_nxt;
    logic              w_ovf;
    logic              w_fast;
    logic [DATA_W-1:0] w_fast_res;
    logic              w_take;

    root_pow_step u_step (
        .i_acc   (r_acc),
        .i_trial (r_trial),
        .i_ix    (r_ix),
        .o_acc   (w_acc_nxt),
        .o_ovf   (w_ovf)
    );

    // Fast-path result. The ordering sets the priority.
    always_comb begin
        w_fast     = 1'b1;
        w_fast_res = '0;
        if (r_n == '0)              w_fast_res = '0;
        else if (r_ix == '0)        w_fast_res = '0;
        else if (r_n == 32'd1)      w_fast_res = r_ix;
        else if (r_n >= 32'd32)     w_fast_res = 32'd1;
        else                        w_fast     = 1'b0;
    end

    assign w_take = (r_acc <= ACC_W'(r_ix));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = w_fast ? S_FIN : S_SETBIT;
            S_SETBIT: w_state_nxt = S_POWER;
            S_POWER: begin
                if (r_cnt == 6'd1) w_state_nxt = S_DECIDE;
`ifdef ROOT_EARLY_EXIT_EN
                else if (w_ovf)    w_state_nxt = S_DECIDE;
`endif
            end
            S_DECIDE: w_state_nxt = (r_bit == 4'd0) ? S_FIN : S_SETBIT;
            S_FIN:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath. result/err are written on the transition into FIN, so
    // they are valid alongside done and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ix     <= '0;
            r_n      <= '0;
            r_root   <= '0;
            r_trial  <= '0;
            r_bit    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_ix <= ix;
                    r_n  <= in;
                end
                S_CHECK: begin
                    if (w_fast) begin
                        r_result <= w_fast_res;
                        r_err    <= (r_n == '0);
                    end else begin
                        r_root <= '0;
                        r_bit  <= 4'(START_BIT);
                    end
                end
                S_SETBIT: begin
                    r_trial <= r_root | (16'd1 << r_bit);
                    r_acc   <= ACC_W'(1);
                    r_cnt   <= r_n[5:0];     // n is 2..31 on this path
                end
                S_POWER: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - 6'd1;
                end
                S_DECIDE: begin
                    if (w_take) r_root <= r_trial;
                    if (r_bit == 4'd0) begin
                        r_result <= {16'd0, (w_take ? r_trial : r_root)};
                        r_err    <= 1'b0;
                    end else begin
                        r_bit <= r_bit - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FIN);
    assign err    = r_err;
    assign result = r_result;

endmodule

// File: tb/tb_int_root.sv
// tb_int_root -- randomized + directed self-checking bench for int_root.
// The reference root comes from a binary search over plain integer powers.
// Expected latency comes from the cycle-count formula. In an early-exit
// build (ROOT_EARLY_EXIT_EN), latency is only checked against the upper
// bound.
module tb_int_root;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] t_ix = '0;
    logic [31:0] t_n  = '0;
    logic        busy, done, err;
    logic [31:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int TIMEOUT = 2000;

    int_root dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ix     (t_ix),
        .in     (t_n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 1 when r^n <= x. The loop bails out as soon as the product passes x.
    function automatic bit pow_le(input longint unsigned r, input int n, input longint unsigned x);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * r;
            if (p > x) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_root(input logic [31:0] x, input logic [31:0] n);
        longint unsigned lo, hi, mid;
        if (n == 0 || x == 0) return 32'd0;
        if (n == 1)           return x;
        if (n >= 32)          return 32'd1;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (pow_le(mid, int'(n), longint'(x))) lo = mid;
            else                                   hi = mid;
        end
        return 32'(lo);
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] n);
        if (n == 0 || x == 0 || n == 1 || n >= 32) return 2;
        return 2 + 16 * (int'(n) + 2);
    endfunction

    // Pulses start for one cycle (cycle T) and waits for done. lat is
    // measured in cycles after T.
    task automatic do_op(input logic [31:0] x, input logic [31:0] n,
                         output int lat, output bit seen);
        @(negedge clk);
        t_ix = x; t_n = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (lat < TIMEOUT) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] x, input logic [31:0] n);
        int lat;
        bit seen;
        do_op(x, n, lat, seen);
        chk({tag, "_done_seen"}, seen, 1'b1);
        if (seen) begin
            chk({tag, "_result"}, result, ref_root(x, n));
            chk({tag, "_err"}, err, (n == 0));
`ifdef ROOT_EARLY_EXIT_EN
            if (ref_lat(x, n) == 2) chk({tag, "_lat"}, lat, 2);
            else                    chk({tag, "_lat_bound"}, (lat <= ref_lat(x, n)), 1'b1);
`else
            chk({tag, "_lat"}, lat, ref_lat(x, n));
`endif
            @(negedge clk);
            chk({tag, "_done_pulse"}, {busy, done}, 2'b00);
        end
    endtask

    initial begin : main
        int lat;
        bit seen;
        bit got_done;
        logic [31:0] prev;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, err, result}, 35'd0);
        rst = 1'b0;

        // directed vectors
        run_check("d_1e6_n2", 32'd1000000, 32'd2);
        run_check("d_27_n3", 32'd27, 32'd3);
        run_check("d_26_n3", 32'd26, 32'd3);
        run_check("d_max_n2", 32'hFFFFFFFF, 32'd2);
        run_check("d_n0", 32'd5, 32'd0);
        run_check("d_n40", 32'd5, 32'd40);
        run_check("d_n1", 32'h12345678, 32'd1);
        run_check("d_ix0", 32'd0, 32'd7);
        run_check("d_n32", 32'hFFFFFFFF, 32'd32);
        run_check("d_n31", 32'hFFFFFFFF, 32'd31);

        // start while busy is ignored; result holds until done
        run_check("d_pre_busy", 32'd26, 32'd3);
        prev = result;
        @(negedge clk);
        t_ix = 32'd1000000; t_n = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        t_ix = 32'd27; t_n = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_held", busy, 1'b1);
        chk("busy_result_hold", result, prev);
        lat = 6; seen = 1'b0;
        while (lat < TIMEOUT) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        chk("busy_done_seen", seen, 1'b1);
        chk("busy_result", result, 32'd1000);
`ifndef ROOT_EARLY_EXIT_EN
        chk("busy_lat", lat, 66);
`endif
        @(negedge clk);
        chk("busy_no_second", {busy, done}, 2'b00);
        repeat (80) @(negedge clk);
        chk("busy_still_idle", {busy, done, result}, {2'b00, 32'd1000});

        // reset mid-operation aborts with no done pulse
        @(negedge clk);
        t_ix = 32'd1000000; t_n = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);     // now in cycle T+20
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {busy, done, err, result}, 35'd0);
        got_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        chk("abort_no_done", got_done, 1'b0);
        run_check("post_rst_81_n4", 32'd81, 32'd4);

        // rst wins over start in the same cycle
        @(negedge clk);
        rst = 1'b1; t_ix = 32'd9; t_n = 32'd2; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_over_start", {busy, result}, 33'd0);

`ifdef ROOT_EARLY_EXIT_EN
        do_op(32'd10, 32'd5, lat, seen);
        chk("ee_done_seen", seen, 1'b1);
        chk("ee_result", result, 32'd1);
        chk("ee_lat_below", (lat < 2 + 16 * 7), 1'b1);
`endif

        // randomized operations
        for (int k = 0; k < 40; k++) begin
            logic [31:0] x, n;
            longint unsigned p;
            int sel;
            sel = int'($urandom_range(0, 4));
            n = (sel == 4) ? 32'($urandom_range(30, 40)) : 32'($urandom_range(0, 10));
            case (sel)
                0: x = $urandom;
                1: x = 32'($urandom_range(0, 100));
                default: begin
                    p = 1;
                    for (int i = 0; i < int'(n); i++) p = p * longint'($urandom_range(2, 12));
                    if (n != 0 && p <= 64'hFFFFFFFF) begin
                        x = 32'(p);
                        if ($urandom_range(0, 1) == 1) x = x - 32'd1;
                    end else begin
                        x = $urandom;
                    end
                end
            endcase
            run_check($sformatf("rnd%0d_x%0h_n%0d", k, x, n), x, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_root.md
INT_ROOT -- requirements
Module: int_root

Interface
REQ-001 The block SHALL have ports as follows; reset is rst, synchronous, active-high; clock is clk.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 ix  input  32  radicand, unsigned; captured on accepted start.
REQ-006 in  input  32  root degree n, unsigned; captured on accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
REQ-008 done  output  1  one-cycle pulse, result valid.
REQ-009 err  output  1  valid with done; high when n == 0.
REQ-010 result  output  32  floor(ix^(1/n)), held until the next accepted start or reset.

Function
REQ-011 States SHALL be IDLE, CHECK, SETBIT, POWER, DECIDE, FIN.
REQ-012 IDLE -> CHECK when start=1, capturing ix and in; start during any other state SHALL be ignored.
REQ-013 CHECK fast paths -> FIN: n==0 gives result=0, err=1; ix==0 gives 0; n==1 gives ix; n>=32 gives 1. Priority is in that order.
REQ-014 Otherwise CHECK SHALL clear the root register and the bit index SHALL be set to 15, then -> SETBIT.
REQ-015 SETBIT: trial = root | (1<<bit); 64-bit acc = 1; loop count = n; -> POWER.
REQ-016 POWER: each cycle acc = acc*trial, then clamp acc to ix+1 if acc > ix; count decrements; -> DECIDE when count reaches 0.
REQ-017 DECIDE: if acc <= ix then root = trial; if bit==0 -> FIN, else bit-1 -> SETBIT.
REQ-018 FIN: done=1 for exactly one cycle, result and err updated, -> IDLE.
REQ-019 Arithmetic: trial <= 16 bits, acc <= 2^32+1, product < 2^49; the 64-bit acc SHALL never wrap.
REQ-020 Fast-path latency: start in cycle T -> done in cycle T+2.
REQ-021 Full-path latency without early exit SHALL be T+2+16*(n+2) (n=2: done at T+66).
REQ-022 err SHALL be 0 on every non-error completion.

Reset
REQ-023 rst SHALL force IDLE, busy=0, done=0, err=0, result=0, and clear all internal registers.
REQ-024 rst asserted mid-operation SHALL abort with no done pulse; the next start SHALL behave as from power-up.
REQ-025 rst has priority over start in the same cycle.

Configuration
REQ-026 ROOT_EARLY_EXIT_EN defined: POWER SHALL exit to DECIDE in the cycle after the clamp first triggers (acc > ix), skipping the remaining multiplies.
REQ-027 ROOT_EARLY_EXIT_EN undefined: POWER SHALL always run exactly n cycles.
REQ-028 result and err SHALL be identical with or without the macro; only latency differs, and the early-exit latency SHALL be at most the REQ-021 bound.

Structure
REQ-029 Shared package root_pkg SHALL hold the state encodings, the 32-bit data-width constant, the 64-bit accumulator-width constant and the start bit index (15).
REQ-030 Sub-module root_pow_step SHALL implement the combinational acc*trial multiply with clamp-to-ix+1 and an overflow flag.
REQ-031 The FSM, counters and registers SHALL reside in int_root.

Verification
REQ-032 ix=1000000, n=2 -> result=1000, err=0; without the macro, done at T+66.
REQ-033 ix=27, n=3 -> 3; ix=26, n=3 -> 2; ix=0xFFFFFFFF, n=2 -> 65535.
REQ-034 n=0, ix=5 -> err=1, result=0, done at T+2; n=40, ix=5 -> 1; n=1, ix=0x12345678 -> 0x12345678; ix=0, n=7 -> 0.
REQ-035 start pulsed while busy -> ignored, result unchanged until the first operation completes.
REQ-036 rst for 1 cycle at T+20 of an n=2 run -> no done; outputs 0; a new start (ix=81, n=4) -> 3.
REQ-037 With the macro defined, ix=10, n=5 -> 1, with latency strictly below T+2+16*7.
